powerup_reset_gen: RTL and testbench

//  Board-level reset generator placed next to the 50 MHz system clock.

---
 rtl/powerup_reset_gen.sv | 116 +++++++++++
 tb/tb_powerup_reset_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/powerup_reset_gen.sv
// Board-level reset generator.
// Holds rst high for POR_CYCLES edges after configuration. A filtered key
// press re-asserts rst, which then stays high for STRETCH_CYCLES edges after
// the key is released. rst and rst_n are registered, so there is no
// combinational path from key to either output.
module powerup_reset_gen #(
    parameter int POR_CYCLES     = 1000,
    parameter int KEY_FILTER     = 2,
    parameter int STRETCH_CYCLES = 256
) (
    input  logic clk,
    input  logic key,
    output logic rst,
    output logic rst_n
);

    localparam int MAX_CYC = (POR_CYCLES > STRETCH_CYCLES) ? POR_CYCLES : STRETCH_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int KCNT_W  = $clog2(KEY_FILTER + 1);

    localparam logic [CNT_W-1:0]  POR_LAST     = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [KCNT_W-1:0] KCNT_LAST    = KCNT_W'(KEY_FILTER - 1);
    localparam logic [KCNT_W-1:0] KCNT_FULL    = KCNT_W'(KEY_FILTER);

    typedef enum logic [1:0] {
        ST_POR,
        ST_RUN,
        ST_HOLD,
        ST_STRETCH
    } state_t;

    // There is no external reset: the declaration values are the
    // configuration-time state, so rst is high from time zero.
    state_t            state_reg  = ST_POR;
    logic [CNT_W-1:0]  cnt_reg    = '0;
    logic [KCNT_W-1:0] kcnt_reg   = '0;
    logic              rst_reg    = 1'b1;
    logic              rst_n_reg  = 1'b0;

    state_t            state_next;
    logic [CNT_W-1:0]  cnt_next;
    logic [KCNT_W-1:0] kcnt_next;
    logic              rst_next;
    logic              press;

    // Key filter: count consecutive key=1 samples, saturating at KEY_FILTER.
    // A press qualifies only on the edge where the count reaches KEY_FILTER,
    // so a held key produces exactly one press.
    always_comb begin
        kcnt_next = kcnt_reg;
        press     = 1'b0;
        if (!key) begin
            kcnt_next = '0;
        end else if (kcnt_reg != KCNT_FULL) begin
            kcnt_next = kcnt_reg + 1'b1;
            press     = (kcnt_reg == KCNT_LAST);
        end
    end

    // Next-state logic. A qualified press wins over any count in progress,
    // so it can only extend reset, never open a gap in it.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_POR: begin
                if (press) begin
                    state_next = ST_HOLD;
                end else if (cnt_reg == POR_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (press) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Counter idles here, so a long hold cannot overflow it.
                if (!key) begin
                    state_next = ST_STRETCH;
                    cnt_next   = '0;
                end
            end
            ST_STRETCH: begin
                if (press) begin
                    state_next = ST_HOLD;
                end else if (cnt_reg == STRETCH_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase
        rst_next = (state_next != ST_RUN);
    end

    // State, counters and both reset outputs update on the same edge.
    always_ff @(posedge clk) begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        kcnt_reg  <= kcnt_next;
        rst_reg   <= rst_next;
        rst_n_reg <= ~rst_next;
    end

    assign rst   = rst_reg;
    assign rst_n = rst_n_reg;

endmodule

// File: tb/tb_powerup_reset_gen.sv
// Testbench for powerup_reset_gen (default parameters: 1000 / 2 / 256).
// Instance dut drives the key scenarios from a vector table through a
// scoreboard queue; instance dut_por sees key=0 forever and checks the plain
// power-up sequence.
module tb_powerup_reset_gen;

    logic clk = 1'b0;
    logic key_a;
    logic key_b;
    logic rst_a, rst_n_a;
    logic rst_b, rst_n_b;

    int check_cnt = 0;
    int err_cnt   = 0;

    always #10 clk = ~clk;

    powerup_reset_gen dut (
        .clk   (clk),
        .key   (key_a),
        .rst   (rst_a),
        .rst_n (rst_n_a)
    );

    powerup_reset_gen dut_por (
        .clk   (clk),
        .key   (key_b),
        .rst   (rst_b),
        .rst_n (rst_n_b)
    );

    typedef struct {
        string name;
        logic  key;
        int    len;
        logic  exp_rst;
    } vec_t;

    typedef struct {
        logic exp_rst;
        int   vec_idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    function automatic void add(string n, logic k, int l, logic e);
        vec_t v;
        v.name    = n;
        v.key     = k;
        v.len     = l;
        v.exp_rst = e;
        vecs.push_back(v);
    endfunction

    task automatic check_bit(string n, logic act, logic req);
        check_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", n, act, req, $time);
        end
    endtask

    task automatic check_int(string n, int act, int req);
        check_cnt++;
        if (act != req) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, act, req, $time);
        end
    endtask

    // Scoreboard: one expected rst per driven edge, compared after that edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_bit({vecs[e.vec_idx].name, " rst"}, rst_a, e.exp_rst);
            check_bit({vecs[e.vec_idx].name, " rst_n"}, rst_n_a, ~e.exp_rst);
        end
    end

    // Power-up with key low: rst high after edges 1..999, low from edge 1000.
    task automatic por_only();
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #3;
            if (n == 999 || n == 1000 || n == 1 || n == 3000 || rst_b !== (n < 1000)) begin
                check_bit($sformatf("por edge %0d rst", n), rst_b, (n < 1000));
                check_bit($sformatf("por edge %0d rst_n", n), rst_n_b, ~(n < 1000));
            end
        end
        $display("por_only: 3000 edges with key=0 observed");
    endtask

    task automatic apply_vectors();
        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].len; c++) begin
                exp_t e;
                key_a     = vecs[i].key;
                e.exp_rst = vecs[i].exp_rst;
                e.vec_idx = i;
                sb_q.push_back(e);
                @(posedge clk);
                #1;
            end
            $display("vector %0d %s: key=%b for %0d edges, rst expected %b",
                     i, vecs[i].name, vecs[i].key, vecs[i].len, vecs[i].exp_rst);
        end
        @(posedge clk);
        #5;
        check_int("scoreboard drained", sb_q.size(), 0);
    endtask

    initial begin
        key_a = 1'b0;
        key_b = 1'b0;

        // Key pulse of 5 cycles starting at edge 65, during POR: reset is
        // continuous and falls 256 edges after release, not at edge 1000.
        add("por_idle",        1'b0,   64, 1'b1);
        add("por_press",       1'b1,    5, 1'b1);
        add("por_stretch",     1'b0,  256, 1'b1);
        add("por_stretch_end", 1'b0,    1, 1'b0);
        add("run_past_1000",   1'b0, 1000, 1'b0);
        // 5-cycle press in RUN: rst rises on the 2nd key-high edge.
        add("press_first",     1'b1,    1, 1'b0);
        add("press_hold",      1'b1,    4, 1'b1);
        add("press_stretch",   1'b0,  256, 1'b1);
        add("press_end",       1'b0,    1, 1'b0);
        add("run_a",           1'b0,   20, 1'b0);
        // Single-cycle glitches separated by one low cycle: the filter count
        // must clear, otherwise the second glitch would qualify.
        add("glitch_1",        1'b1,    1, 1'b0);
        add("glitch_gap",      1'b0,    1, 1'b0);
        add("glitch_2",        1'b1,    1, 1'b0);
        add("glitch_after",    1'b0,   30, 1'b0);
        // Re-press after 100 edges of STRETCH restarts the full stretch.
        add("rp_first",        1'b1,    1, 1'b0);
        add("rp_hold",         1'b1,    2, 1'b1);
        add("rp_stretch_100",  1'b0,  100, 1'b1);
        add("rp_press2",       1'b1,    3, 1'b1);
        add("rp_stretch",      1'b0,  256, 1'b1);
        add("rp_end",          1'b0,    1, 1'b0);
        add("run_b",           1'b0,   10, 1'b0);
        // Press qualifying on the very edge the stretch would have ended.
        add("edge_first",      1'b1,    1, 1'b0);
        add("edge_hold",       1'b1,    1, 1'b1);
        add("edge_stretch",    1'b0,  255, 1'b1);
        add("edge_press",      1'b1,    2, 1'b1);
        add("edge_stretch2",   1'b0,  256, 1'b1);
        add("edge_end",        1'b0,    1, 1'b0);
        add("run_c",           1'b0,   10, 1'b0);
        // Long hold: no overflow, exact 256-edge stretch afterwards.
        add("long_first",      1'b1,    1, 1'b0);
        add("long_hold",       1'b1, 9999, 1'b1);
        add("long_stretch",    1'b0,  256, 1'b1);
        add("long_end",        1'b0,    1, 1'b0);
        add("run_d",           1'b0,   10, 1'b0);

        // Configuration-time values, before any clock edge.
        #1;
        check_bit("init rst", rst_a, 1'b1);
        check_bit("init rst_n", rst_n_a, 1'b0);
        check_bit("init por rst", rst_b, 1'b1);
        check_bit("init por rst_n", rst_n_b, 1'b0);

        fork
            por_only();
            apply_vectors();
        join

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
